uart_rx_peripheral: RTL and testbench

UART receiver peripheral, the receive-side counterpart of the UART TX peripheral. Oversamples the asynchronous serial input 16x on the system clock, validates the start bit, majority-votes each bit, and checks stop and optional parity. Presents each received byte, with its error flags, in a one-deep holding register behind a valid/ready handshake toward the core-side bus logic.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 71 +++++++
 rtl/uart_rx_peripheral.sv | 136 +++++++++++++
 tb/tb_uart_rx_peripheral.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// oversampling geometry and the mid-bit sample positions.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4
    } uart_rx_state_e;

    localparam int UART_RX_OVERSAMPLE = 16;
    localparam int UART_RX_DATA_BITS  = 8;

    localparam logic [3:0] UART_RX_SAMPLE_A = 4'd7;
    localparam logic [3:0] UART_RX_SAMPLE_B = 4'd8;
    localparam logic [3:0] UART_RX_SAMPLE_C = 4'd9;

    function automatic logic uart_rx_majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, start-edge detect, prescaler, 16x tick
// index and 3-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_sdata,
    input  logic run,
    output logic start_edge,
    output logic bit_decide,
    output logic bit_value,
    output logic bit_end
);

    localparam int PW = $clog2(CLKS_PER_TICK);

    logic          sync1, sync2, sync_prev;
    logic [PW-1:0] presc;
    logic [3:0]    tick;
    logic          samp_a, samp_b;
    logic          wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_sdata;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign start_edge = sync_prev & ~sync2;
    assign wrap       = run && (presc == PW'(CLKS_PER_TICK - 1));

    // Counters sit at zero whenever the FSM is idle, so START always begins at 0/0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            tick  <= '0;
        end else if (!run) begin
            presc <= '0;
            tick  <= '0;
        end else if (wrap) begin
            presc <= '0;
            tick  <= tick + 4'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else if (wrap) begin
            if (tick == UART_RX_SAMPLE_A) samp_a <= sync2;
            if (tick == UART_RX_SAMPLE_B) samp_b <= sync2;
        end
    end

    assign bit_decide = wrap && (tick == UART_RX_SAMPLE_C);
    assign bit_value  = uart_rx_majority3(samp_a, samp_b, sync2);
    assign bit_end    = wrap && (tick == 4'(UART_RX_OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_peripheral.sv
// UART receiver: frame FSM, shift register and one-deep holding register.
// Define UART_RX_PARITY_EN to compile in the parity bit and its check.
module uart_rx_peripheral
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic       i_uart_clk,
    input  logic       i_uart_rst,
    input  logic       i_uart_rx_sdata,
    input  logic       i_uart_parity_type,
    input  logic       i_uart_rx_ready,
    output logic [7:0] o_uart_rx_pdata,
    output logic       o_uart_rx_valid,
    output logic       o_uart_rx_frame_err,
    output logic       o_uart_rx_parity_err,
    output logic       o_uart_rx_overrun,
    output logic       o_uart_rx_busy
);

    localparam logic [2:0] ST_IDLE   = 3'(UART_RX_IDLE);
    localparam logic [2:0] ST_START  = 3'(UART_RX_START);
    localparam logic [2:0] ST_DATA   = 3'(UART_RX_DATA);
    localparam logic [2:0] ST_STOP   = 3'(UART_RX_STOP);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'(UART_RX_PARITY);
`endif

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       start_edge, bit_decide, bit_value, bit_end;
    logic       load_req, load_ok;

    uart_rx_sampler #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_sampler (
        .clk        (i_uart_clk),
        .rst        (i_uart_rst),
        .rx_sdata   (i_uart_rx_sdata),
        .run        (state != ST_IDLE),
        .start_edge (start_edge),
        .bit_decide (bit_decide),
        .bit_value  (bit_value),
        .bit_end    (bit_end)
    );

    always_ff @(posedge i_uart_clk or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_decide && bit_value) state <= ST_IDLE;
                    else if (bit_end)            state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_decide) shreg <= {bit_value, shreg[7:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(UART_RX_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) state <= ST_STOP;
                end
`endif
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                ST_STOP: begin
                    if (bit_decide) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign load_req = (state == ST_STOP) && bit_decide;
    assign load_ok  = load_req && (!o_uart_rx_valid || i_uart_rx_ready);

    always_ff @(posedge i_uart_clk or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            o_uart_rx_pdata     <= '0;
            o_uart_rx_frame_err <= 1'b0;
            o_uart_rx_valid     <= 1'b0;
        end else if (load_ok) begin
            o_uart_rx_pdata     <= shreg;
            o_uart_rx_frame_err <= !bit_value;
            o_uart_rx_valid     <= 1'b1;
        end else if (o_uart_rx_valid && i_uart_rx_ready) begin
            o_uart_rx_valid     <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_q, hold_par_err;

    // Even type: parity bit equals XOR of data; odd type inverts it.
    always_ff @(posedge i_uart_clk or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            par_err_q <= 1'b0;
        end else if (state == ST_IDLE && start_edge) begin
            par_err_q <= 1'b0;
        end else if (state == ST_PARITY && bit_decide) begin
            par_err_q <= bit_value != (^shreg ^ i_uart_parity_type);
        end
    end

    always_ff @(posedge i_uart_clk or posedge i_uart_rst) begin
        if (i_uart_rst)   hold_par_err <= 1'b0;
        else if (load_ok) hold_par_err <= par_err_q;
    end

    assign o_uart_rx_parity_err = hold_par_err;
`else
    logic unused_parity_type;
    assign unused_parity_type   = i_uart_parity_type;
    assign o_uart_rx_parity_err = 1'b0;
`endif

    assign o_uart_rx_overrun = load_req && o_uart_rx_valid && !i_uart_rx_ready;
    assign o_uart_rx_busy    = state != ST_IDLE;

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Randomized bench for uart_rx_peripheral: frames are built from bits, the
// model predicts delivered bytes/flags and overrun drops from the frame rules.
module tb_uart_rx_peripheral;

    localparam int CPT = 4;
    localparam int BIT = 16 * CPT;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NB     = 11;
    localparam int LAT    = 170;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NB     = 10;
    localparam int LAT    = 154;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ptype = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] pdata;
    logic       valid, ferr, perr, ovr, busy;

    uart_rx_peripheral #(.CLKS_PER_TICK(CPT)) dut (
        .i_uart_clk           (clk),
        .i_uart_rst           (rst),
        .i_uart_rx_sdata      (rx),
        .i_uart_parity_type   (ptype),
        .i_uart_rx_ready      (ready),
        .o_uart_rx_pdata      (pdata),
        .o_uart_rx_valid      (valid),
        .o_uart_rx_frame_err  (ferr),
        .o_uart_rx_parity_err (perr),
        .o_uart_rx_overrun    (ovr),
        .o_uart_rx_busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor: items are {frame_err, parity_err, data}.
    logic [9:0] got_q[$];
    logic [9:0] sb[$];
    int   rise_cyc = 0;
    int   ovr_cnt = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= valid;
        if (valid && ready) got_q.push_back({ferr, perr, pdata});
        if (ovr) ovr_cnt <= ovr_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;
    int exp_ovr = 0;
    int fall_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Build and send one frame; optional glitch inverts the line inside one bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              input int gbit, input int gstart, input int glen);
        logic [10:0] fr;
        fr     = '1;
        fr[0]  = 1'b0;
        fr[8:1] = d;
        if (PAR_EN) begin
            fr[9]  = ^d ^ ptype ^ flip;
            fr[10] = stop;
        end else begin
            fr[9] = stop;
        end
        if (sb.size() > got_q.size() && !ready) exp_ovr++;
        else sb.push_back({!stop, PAR_EN & flip, d});
        fall_cyc = cyc;
        for (int i = 0; i < NB; i++) begin
            if (i == gbit) begin
                drive(fr[i], gstart);
                drive(!fr[i], glen);
                drive(fr[i], BIT - gstart - glen);
            end else begin
                drive(fr[i], BIT);
            end
        end
    endtask

    task automatic drain(input string tag);
        logic [9:0] g, e;
        chk({tag, "_count"}, got_q.size(), sb.size());
        while (got_q.size() > 0 && sb.size() > 0) begin
            g = got_q.pop_front();
            e = sb.pop_front();
            chk(tag, {22'd0, g}, {22'd0, e});
        end
        got_q.delete();
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pdata"}, pdata, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_ferr"}, ferr, 0);
        chk({tag, "_perr"}, perr, 0);
        chk({tag, "_ovr"}, ovr, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        repeat (5) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        drive(1'b1, 20);
        chk_all_zero("post_reset");

        // Basic receive and valid latency from START entry.
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0, 0);
        chk("valid_latency", rise_cyc - fall_cyc, 3 + LAT * CPT);
        drive(1'b1, 10);
        drain("basic");

        // Parity: correct then wrong parity bit, even type.
        ptype = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0, 0);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 0, 0);
        drive(1'b1, 10);
        drain("parity");

        // One-tick glitch is a false start; no byte, busy drops within a bit.
        drive(1'b0, CPT);
        drive(1'b1, 8);
        chk("glitch_busy_hi", busy, 1);
        drive(1'b1, BIT - 8);
        chk("glitch_busy_lo", busy, 0);
        drain("glitch");

        // Two-tick glitch in data bit 3 overlaps only one of the three samples.
        send_frame(8'hFF, 1'b1, 1'b0, 4, 38, 2 * CPT);
        drive(1'b1, 10);
        drain("midbit_glitch");

        // Framing error, then a break of three frame times.
        send_frame(8'h55, 1'b0, 1'b0, -1, 0, 0);
        drive(1'b1, BIT);
        drain("frame_err");
        sb.push_back({1'b1, 1'b0, 8'h00});
        drive(1'b0, 3 * NB * BIT);
        drive(1'b1, 2 * BIT);
        drain("break");

        // Overrun: second byte dropped while the first is held.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1, 0, 0);
        send_frame(8'h22, 1'b1, 1'b0, -1, 0, 0);
        drive(1'b1, 10);
        chk("ovr_hold_data", pdata, 8'h11);
        chk("ovr_hold_valid", valid, 1);
        chk("ovr_pulses", ovr_cnt, exp_ovr);
        ready = 1'b1;
        drive(1'b1, 2);
        chk("ovr_valid_fall", valid, 0);
        drain("overrun");

        // Reset during data bit 4 with a byte still held.
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, -1, 0, 0);
        drive(1'b1, 10);
        d = 8'hEE;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(d[i], BIT);
        drive(d[4], 20);
        chk("rst_mid_busy", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        drive(1'b1, 4);
        rst = 1'b0;
        sb.delete();
        got_q.delete();
        ready = 1'b1;
        drive(1'b1, BIT);
        send_frame(8'h81, 1'b1, 1'b0, -1, 0, 0);
        drive(1'b1, 10);
        drain("after_rst");

        // Random frames with random stop errors, parity type and corruption.
        for (int n = 0; n < 16; n++) begin
            logic st;
            st    = ($urandom_range(0, 4) != 0);
            ptype = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), st, 1'($urandom_range(0, 1)), -1, 0, 0);
            drive(1'b1, st ? $urandom_range(0, 20) : $urandom_range(1, 20));
        end
        drive(1'b1, 10);
        drain("random");
        chk("ovr_total", ovr_cnt, exp_ovr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
